// File: rtl/boolean_bist_pkg.sv
// Shared types and constants for the boolean_bist self-test engine.
// Holds the FSM state enum and the mismatch priority encoder.
package bist_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } bist_state_t;

    localparam int VEC_COUNT = 8;
    localparam int IDX_W     = 3;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [IDX_W-1:0] first_set(
        input logic [VEC_COUNT-1:0] v
    );
        first_set = '0;
        for (int i = VEC_COUNT - 1; i >= 0; i--) begin
            if (v[i]) first_set = IDX_W'(i);
        end
    endfunction

endpackage

// File: rtl/boolean_bist_if.sv
// Signal bundle between the BIST engine and its host / block under test.
// slave is the engine side, master the host side.
interface boolean_bist_if;
    import bist_pkg::*;

    logic                 start;
    logic                 y_in;
    logic                 a;
    logic                 b;
    logic                 c;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [VEC_COUNT-1:0] signature;
    logic [IDX_W-1:0]     fail_index;

    modport master (
        output start, y_in,
        input  a, b, c, busy, done, pass, signature, fail_index
    );

    modport slave (
        input  start, y_in,
        output a, b, c, busy, done, pass, signature, fail_index
    );

endinterface

// File: rtl/boolean_bist_settle_timer.sv
// Counts the cycles each stimulus vector is held.
// tick marks the last settle cycle, where y_in is captured.
module bist_settle_timer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam logic [7:0] LAST = 8'(SETTLE_CYCLES - 1);

    logic [7:0] count;

    assign tick = enable && (count == LAST);

    // Free-run while enabled, wrapping to 0 on each tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 8'd0;
        end else if (clear) begin
            count <= 8'd0;
        end else if (enable) begin
            count <= tick ? 8'd0 : count + 8'd1;
        end
    end

endmodule

// File: rtl/boolean_bist.sv
// Exhaustive truth-table self-test for a 3-input combinational block.
// Sweeps {a,b,c}, captures y_in per vector, compares with EXPECTED.
import bist_pkg::*;

module boolean_bist #(
    parameter logic [7:0] EXPECTED      = 8'hEA,
    parameter int         SETTLE_CYCLES = 2
) (
    input logic           clk,
    input logic           rst_n,
    boolean_bist_if.slave bus
);

    bist_state_t          state;
    logic [IDX_W-1:0]     idx;
    logic [VEC_COUNT-1:0] sig_next;
    logic                 tick;

    bist_settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .enable(state == RUN),
        .clear (state != RUN),
        .tick  (tick)
    );

    // Signature with the current vector's response folded in.
    always_comb begin
        sig_next      = bus.signature;
        sig_next[idx] = bus.y_in;
    end

    // Sweep sequencer with registered stimulus and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            idx            <= '0;
            {bus.a, bus.b, bus.c} <= 3'b000;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.pass       <= 1'b0;
            bus.signature  <= '0;
            bus.fail_index <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state          <= RUN;
                        idx            <= '0;
                        {bus.a, bus.b, bus.c} <= 3'b000;
                        bus.busy       <= 1'b1;
                        bus.done       <= 1'b0;
                        bus.pass       <= 1'b0;
                        bus.signature  <= '0;
                        bus.fail_index <= '0;
                    end
                end
                RUN: begin
                    if (tick) begin
                        bus.signature <= sig_next;
                        idx           <= idx + 1'b1;
                        {bus.a, bus.b, bus.c} <= idx + 1'b1;
                        if (idx == IDX_W'(VEC_COUNT - 1)) begin
                            state          <= DONE;
                            bus.busy       <= 1'b0;
                            bus.done       <= 1'b1;
                            bus.pass       <= (sig_next == EXPECTED);
                            bus.fail_index <= first_set(sig_next ^ EXPECTED);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/boolean_bist.md
# boolean_bist

Built-in self-test engine for the three-input combinational `boolean_expression` block. It drives all eight `{a,b,c}` input vectors into the block under test and waits a programmable settle time for each one. It then samples the block's output `y` and assembles an 8-bit truth-table signature. The signature is compared against an expected value, and the engine reports pass/fail plus the first failing vector. It sits beside `boolean_expression` in the top-level and replaces the simulation-only exhaustive sweep with a synthesizable on-chip check.

## Interface
Parameters:
- `EXPECTED`, default 8'hEA — golden truth table; bit i = expected y for vector i, where i = {a,b,c} and a is the MSB. 8'hEA corresponds to y = (a&b)|c.
- `SETTLE_CYCLES`, default 2 — clock cycles each vector is held before sampling; legal range 1..255.

Ports:
- `clk`  in  1  — system clock, rising edge.
- `rst_n`  in  1  — reset, asynchronous and active-low.
- `start`  in  1  — request a test run; sampled in IDLE or DONE only.
- `y_in`  in  1  — output of the block under test.
- `a`, `b`, `c`  out  1 each  — stimulus to the block under test; registered.
- `busy`  out  1  — high while a sweep is in progress.
- `done`  out  1  — high in DONE; held until the next accepted start or reset.
- `pass`  out  1  — valid while done=1; 1 when signature == EXPECTED.
- `signature`  out  8  — captured truth table.
- `fail_index`  out  3  — lowest i where signature[i] != EXPECTED[i]; 0 when pass=1.

## Operation
- State machine states: IDLE, RUN, DONE.
- Reset values: state IDLE, idx=0, settle counter 0, a=b=c=0, busy=0, done=0, pass=0, signature=0, fail_index=0.
- IDLE → RUN on start=1:
  - idx=0, abc=000, settle counter=0, signature cleared to 0, busy=1.
- RUN:
  - The settle counter increments each cycle.
  - On the edge where the counter equals SETTLE_CYCLES−1:
    - signature[idx] ← y_in;
    - counter ← 0;
    - idx ← idx+1, and abc follows idx on the same edge.
- Wrap-around: idx is 3 bits. The capture at idx=7 wraps idx to 0, so abc returns to 000. That same edge moves the state to DONE.
- On entry to DONE, all registered on the final capture edge:
  - busy=0, done=1;
  - pass = (signature_next == EXPECTED);
  - fail_index = priority encode (lowest set bit) of signature_next ^ EXPECTED.
- DONE → RUN on start=1. The new run is identical to one started from IDLE, and done/pass/fail_index clear on that edge.
- start=1 while in RUN is ignored.
- Reset asserted mid-run: immediate asynchronous return to the reset values. No partial signature is retained.
- Width rule: the settle counter is 8 bits and compares against SETTLE_CYCLES−1.

## Timing
- Let E0 be the edge that samples start=1. After E0: busy=1 and abc=000.
- Vector i is driven for exactly SETTLE_CYCLES cycles. y_in is sampled on the last edge of that window.
- Capture edge for vector i: E0 + (i+1)·SETTLE_CYCLES.
- done rises after edge E0 + 8·SETTLE_CYCLES (16 cycles at the default). busy falls on the same edge.
- y_in is assumed combinationally settled within SETTLE_CYCLES cycles of the abc change. No synchronizer is needed because y_in is in the same clock domain.

## Structure
- Shared package `bist_pkg`:
  - state enum `bist_state_t` {IDLE, RUN, DONE};
  - localparam `VEC_COUNT` = 8;
  - localparam `IDX_W` = 3.
- One sub-module, `bist_settle_timer`:
  - parameter SETTLE_CYCLES;
  - inputs clk, rst_n, enable, clear;
  - output `tick`, a one-cycle pulse on the last settle cycle.
- Top-level `boolean_bist_top`-style integration instantiates `boolean_bist` and `boolean_expression`, with y connected to y_in.

## Test plan
- Golden DUT y=(a&b)|c, defaults; pulse start → busy for 16 cycles; then done=1, signature=8'hEA, pass=1, fail_index=0; abc visited 000…111 in order, each held 2 cycles.
- y_in stuck-at-0 → signature=8'h00, pass=0, fail_index=1.
- y_in inverted only at vector 6 (abc=110) → signature=8'hAA, pass=0, fail_index=6.
- SETTLE_CYCLES=1 with the golden DUT → done exactly 8 cycles after the start edge; signature=8'hEA.
- start re-pulsed mid-run at cycle 5 → ignored, done still at cycle 16. Then rst_n pulsed low at cycle 9 of a second run → all outputs 0 immediately. A restart after reset completes with pass=1.
- start asserted while in DONE → done/pass clear on the next edge and a full new 16-cycle sweep runs.
